float_minmax_reduce_16bit: RTL and testbench

Streaming min/max reduction unit for IEEE-754 half-precision vectors. It accepts a programmed number of elements over a valid/ready input handshake. It returns the minimum or maximum value and that element's index over a valid/ready output handshake. Each element is compared combinationally by a float_minmax_16bit instance, with RISC-V fmin/fmax semantics. It sits behind the FPU vector issue path and feeds reduction results back to the writeback/response stage.

---
 rtl/fpu_types_pkg.sv | 29 ++
 rtl/float_minmax_16bit.sv | 42 ++++
 rtl/float_minmax_reduce_16bit.sv | 131 +++++++++++++
 tb/tb_float_minmax_reduce_16bit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// Shared half-precision constants, helpers and the reduction state type.
package fpu_types_pkg;

  localparam int unsigned HALF_FLOAT_W    = 16;
  localparam int unsigned HALF_EXPONENT_W = 5;
  localparam int unsigned HALF_FRACTION_W = 10;

  localparam logic [HALF_FLOAT_W-1:0] HALF_INF  = 16'h7C00;
  localparam logic [HALF_FLOAT_W-1:0] HALF_INFN = 16'hFC00;
  localparam logic [HALF_FLOAT_W-1:0] HALF_NAN  = 16'h7E00;
  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } reduce_state_t;

  // Exponent all ones with a nonzero fraction.
  function automatic logic half_is_nan(input logic [HALF_FLOAT_W-1:0] f);
    return (&f[HALF_FLOAT_W-2 -: HALF_EXPONENT_W]) && (|f[HALF_FRACTION_W-1:0]);
  endfunction

  // NaN whose quiet bit (fraction MSB) is clear.
  function automatic logic half_is_snan(input logic [HALF_FLOAT_W-1:0] f);
    return half_is_nan(f) && !f[HALF_FRACTION_W-1];
  endfunction

endpackage

// File: rtl/float_minmax_16bit.sv
// Combinational half-float min/max with fmin/fmax NaN and signed-zero rules.
module float_minmax_16bit
  import fpu_types_pkg::*;
(
  input  logic [HALF_FLOAT_W-1:0] float1,
  input  logic [HALF_FLOAT_W-1:0] float2,
  input  logic                    max,
  output logic [HALF_FLOAT_W-1:0] result_c
);

  logic nan1;
  logic nan2;
  logic lt;

  // Sign-magnitude ordering: -0 sorts below +0 because signs differ.
  always_comb begin
    nan1 = half_is_nan(float1);
    nan2 = half_is_nan(float2);
    lt   = 1'b0;
    if (float1[HALF_FLOAT_W-1] != float2[HALF_FLOAT_W-1]) begin
      lt = float1[HALF_FLOAT_W-1];
    end else if (float1[HALF_FLOAT_W-1]) begin
      lt = float1[HALF_FLOAT_W-2:0] > float2[HALF_FLOAT_W-2:0];
    end else begin
      lt = float1[HALF_FLOAT_W-2:0] < float2[HALF_FLOAT_W-2:0];
    end

    result_c = float1;
    if (nan1 && nan2) begin
      result_c = HALF_NAN;
    end else if (nan1) begin
      result_c = float2;
    end else if (nan2) begin
      result_c = float1;
    end else if (max) begin
      result_c = lt ? float2 : float1;
    end else begin
      result_c = lt ? float1 : float2;
    end
  end

endmodule

// File: rtl/float_minmax_reduce_16bit.sv
// Streaming half-float min/max reduction returning the value and its arrival index.
module float_minmax_reduce_16bit
  import fpu_types_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned IDX_W   = $clog2(MAX_LEN),
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    max,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HALF_FLOAT_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_FLOAT_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    nv_flag,
  output logic                    len_err,
  output logic                    busy
);

  reduce_state_t           state;
  logic [LEN_W-1:0]        len_q;
  logic                    max_q;
  logic [LEN_W-1:0]        count;
  logic [HALF_FLOAT_W-1:0] best;
  logic [IDX_W-1:0]        best_idx;

  logic [HALF_FLOAT_W-1:0] cmp_res;
  logic [HALF_FLOAT_W-1:0] next_best;
  logic [IDX_W-1:0]        next_idx;
  logic [LEN_W-1:0]        count_inc;
  logic                    in_nan;
  logic                    beat;

  float_minmax_16bit u_cmp (
    .float1   (best),
    .float2   (in_data),
    .max      (max_q),
    .result_c (cmp_res)
  );

  // Candidate running result; the index moves only on a real (non-NaN) change.
  always_comb begin
    in_nan    = half_is_nan(in_data);
    beat      = in_valid && in_ready;
    count_inc = count + LEN_W'(1);
    next_best = cmp_res;
    next_idx  = best_idx;
    if (count == '0) begin
      next_best = in_data;
      next_idx  = '0;
    end else if (!in_nan && (cmp_res != best)) begin
      next_idx = IDX_W'(count);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      len_q     <= '0;
      max_q     <= 1'b0;
      count     <= '0;
      best      <= '0;
      best_idx  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      nv_flag   <= 1'b0;
      len_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            max_q   <= max;
            count   <= '0;
            nv_flag <= 1'b0;
            len_err <= 1'b0;
            busy    <= 1'b1;
            if ((len == '0) || (len > LEN_W'(MAX_LEN))) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= HALF_NAN;
              out_index <= '0;
              len_err   <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            best     <= next_best;
            best_idx <= next_idx;
            count    <= count_inc;
            if (half_is_snan(in_data)) begin
              nv_flag <= 1'b1;
            end
            if (count_inc == len_q) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= half_is_nan(next_best) ? HALF_NAN : next_best;
              out_index <= next_idx;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_minmax_reduce_16bit.sv
// Scoreboard bench for the half-float min/max reduction unit.
module tb_float_minmax_reduce_16bit;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned LEN_W   = 6;

  typedef struct packed {
    logic [15:0]      d;
    logic [IDX_W-1:0] idx;
    logic             nv;
    logic             le;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             max = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_data;
  logic [IDX_W-1:0] out_index;
  logic             nv_flag;
  logic             len_err;
  logic             busy;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   pushes   = 0;
  int   pops     = 0;
  exp_t expq[$];
  logic [15:0] vec [0:MAX_LEN-1];

  float_minmax_reduce_16bit #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .max(max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .nv_flag(nv_flag), .len_err(len_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Monitor: compares each presented result, and stability while stalled.
  initial begin
    exp_t        e;
    logic        pv = 1'b0;
    logic [15:0] pd = '0;
    logic [IDX_W-1:0] pi = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (out_valid) begin
        chk("done_in_ready", 32'(in_ready), 32'd0);
        if (pv) begin
          chk("hold_data", 32'(out_data), 32'(pd));
          chk("hold_index", 32'(out_index), 32'(pi));
        end
        if (out_ready) begin
          pv = 1'b0;
          if (expq.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_result: got %h with no expected entry", out_data);
          end else begin
            e = expq.pop_front();
            pops++;
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_index", 32'(out_index), 32'(e.idx));
            chk("nv_flag", 32'(nv_flag), 32'(e.nv));
            chk("len_err", 32'(len_err), 32'(e.le));
          end
        end else begin
          pv = 1'b1;
          pd = out_data;
          pi = out_index;
        end
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic send(input logic [15:0] d, input int gap);
    int t = 0;
    repeat (gap) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (out_valid && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) chk("result_timeout", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input int l, input logic m, input exp_t e, input int gmax, input int hold);
    int nb;
    nb = (l == 0 || l > int'(MAX_LEN)) ? 0 : l;
    expq.push_back(e);
    pushes++;
    if (hold > 0) out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    len   = LEN_W'(l);
    max   = m;
    @(negedge CLK);
    start = 1'b0;
    if (nb == 0) begin
      chk("err_in_ready", 32'(in_ready), 32'd0);
      chk("err_out_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < nb; i++) send(vec[i], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    chk("latency", 32'(out_valid), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      out_ready = 1'b1;
      @(negedge CLK);
      chk("stall_busy_clear", 32'(busy), 32'd0);
      chk("stall_valid_clear", 32'(out_valid), 32'd0);
    end
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    RST = 1'b0;

    // max of four
    vec[0] = 16'h3C00; vec[1] = 16'h4000; vec[2] = 16'hBC00; vec[3] = 16'h3800;
    run(4, 1'b1, '{d: 16'h4000, idx: 5'd1, nv: 1'b0, le: 1'b0}, 0, 0);

    // signed zeros
    vec[0] = 16'h0000; vec[1] = 16'h8000; vec[2] = 16'h3C00;
    run(3, 1'b0, '{d: 16'h8000, idx: 5'd1, nv: 1'b0, le: 1'b0}, 0, 0);
    run(2, 1'b1, '{d: 16'h0000, idx: 5'd0, nv: 1'b0, le: 1'b0}, 0, 0);
    run(3, 1'b1, '{d: 16'h3C00, idx: 5'd2, nv: 1'b0, le: 1'b0}, 0, 0);

    // NaN handling
    vec[0] = 16'h7E00; vec[1] = 16'h7C01; vec[2] = 16'hBC00; vec[3] = 16'h7C00;
    run(4, 1'b0, '{d: 16'hBC00, idx: 5'd2, nv: 1'b1, le: 1'b0}, 0, 0);
    vec[0] = 16'h7C01; vec[1] = 16'h7E00;
    run(2, 1'b0, '{d: 16'h7E00, idx: 5'd0, nv: 1'b1, le: 1'b0}, 0, 0);

    // handshake stress: random gaps, result stalled 5 cycles
    vec[0] = 16'h4800; vec[1] = 16'h4400; vec[2] = 16'hC400; vec[3] = 16'h4200;
    run(4, 1'b0, '{d: 16'hC400, idx: 5'd2, nv: 1'b0, le: 1'b0}, 3, 5);

    // length edges
    run(0, 1'b0, '{d: 16'h7E00, idx: 5'd0, nv: 1'b0, le: 1'b1}, 0, 0);
    run(40, 1'b1, '{d: 16'h7E00, idx: 5'd0, nv: 1'b0, le: 1'b1}, 0, 0);
    vec[0] = 16'hC000;
    run(1, 1'b1, '{d: 16'hC000, idx: 5'd0, nv: 1'b0, le: 1'b0}, 0, 0);
    for (int i = 0; i < int'(MAX_LEN); i++) vec[i] = 16'h3C00 + 16'(i * 256);
    run(32, 1'b1, '{d: 16'h5B00, idx: 5'd31, nv: 1'b0, le: 1'b0}, 0, 0);
    run(32, 1'b0, '{d: 16'h3C00, idx: 5'd0, nv: 1'b0, le: 1'b0}, 0, 0);

    // reset after 2 of 4 beats
    @(negedge CLK);
    start = 1'b1; len = 6'd4; max = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    send(16'h4000, 0);
    send(16'h4400, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_index", 32'(out_index), 32'd0);
    chk("mid_rst_nv", 32'(nv_flag), 32'd0);
    chk("mid_rst_len_err", 32'(len_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    // fresh reduction with a start pulse (and mode change) during ACCUM
    expq.push_back('{d: 16'h3C00, idx: 5'd2, nv: 1'b0, le: 1'b0});
    pushes++;
    start = 1'b1; len = 6'd3; max = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    send(16'h3800, 0);
    start = 1'b1; len = 6'd1; max = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    chk("accum_start_ignored", 32'(in_ready), 32'd1);
    send(16'h3400, 0);
    send(16'h3C00, 0);
    chk("latency_after_pulse", 32'(out_valid), 32'd1);
    wait_idle();

    repeat (3) @(negedge CLK);
    chk("results_consumed", 32'(pops), 32'(pushes));
    chk("final_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
